// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between N_REQ write-back requesters.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module regfile_wb_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    reg_write_enable,
  output logic [ADDR_W-1:0]       write_address,
  output logic [DATA_W-1:0]       write_data,
  output logic [31:0]             pending_mask
);

  localparam int unsigned N_REGS = 32;

`ifdef WB_ARB_RR_EN
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
`endif

  logic [ADDR_W-1:0] w_addr [N_REQ];
  logic [DATA_W-1:0] w_data [N_REQ];
  logic [N_REQ-1:0]  w_cand;
  logic [N_REQ-1:0]  w_x0;
  logic [N_REQ-1:0]  w_gnt;
  logic              w_found;
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_gdata;
  logic [31:0]       w_mask;

  logic              r_we;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;

  // Unpack requester lanes; writes to x0 are acknowledged but never arbitrated
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
      w_data[i] = req_data[i*DATA_W +: DATA_W];
      w_x0[i]   = req_valid[i] && (w_addr[i] == '0);
      w_cand[i] = req_valid[i] && (w_addr[i] != '0);
    end
  end

  // Pick at most one candidate per cycle
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_gaddr = '0;
    w_gdata = '0;
`ifdef WB_ARB_RR_EN
    w_ptr_nxt = r_ptr;
    // First pass covers indices at/after the pointer, second pass wraps to the low indices
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && w_cand[i] && (PTR_W'(i) >= r_ptr)) begin
        w_found   = 1'b1;
        w_gnt[i]  = 1'b1;
        w_gaddr   = w_addr[i];
        w_gdata   = w_data[i];
        w_ptr_nxt = (i + 1 == int'(N_REQ)) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && w_cand[i]) begin
        w_found   = 1'b1;
        w_gnt[i]  = 1'b1;
        w_gaddr   = w_addr[i];
        w_gdata   = w_data[i];
        w_ptr_nxt = (i + 1 == int'(N_REQ)) ? '0 : PTR_W'(i + 1);
      end
    end
`else
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && w_cand[i]) begin
        w_found  = 1'b1;
        w_gnt[i] = 1'b1;
        w_gaddr  = w_addr[i];
        w_gdata  = w_data[i];
      end
    end
`endif
  end

  assign req_ready = {N_REQ{reset_n}} & (w_x0 | w_gnt);

  // Output stage drains every cycle; address/data hold while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we  <= 1'b0;
      r_wa  <= '0;
      r_wd  <= '0;
`ifdef WB_ARB_RR_EN
      r_ptr <= '0;
`endif
    end else begin
      r_we <= w_found;
      if (w_found) begin
        r_wa <= w_gaddr;
        r_wd <= w_gdata;
      end
`ifdef WB_ARB_RR_EN
      r_ptr <= w_ptr_nxt;
`endif
    end
  end

  // Registers with a write in the output stage or still waiting for a grant
  always_comb begin
    w_mask = '0;
    for (int r = 1; r < int'(N_REGS); r++) begin
      w_mask[r] = r_we && (int'(r_wa) == r);
      for (int i = 0; i < N_REQ; i++) begin
        if (w_cand[i] && (int'(w_addr[i]) == r)) w_mask[r] = 1'b1;
      end
    end
  end

  assign reg_write_enable = r_we;
  assign write_address    = r_wa;
  assign write_data       = r_wd;
  assign pending_mask     = w_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: arbitration model + write scoreboard + scenario tasks.
// Expected grant order follows WB_ARB_RR_EN when the macro is defined for the build.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  valid;
  logic [AW-1:0] ra [N];
  logic [DW-1:0] rd [N];

  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            reg_write_enable;
  logic [AW-1:0]   write_address;
  logic [DW-1:0]   write_data;
  logic [31:0]     pending_mask;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t q[$];
  int  n_vec = 0;
  int  n_err = 0;

  // Model of the output stage and arbitration pointer
  int            m_ptr = 0;
  logic          m_we  = 1'b0;
  logic [AW-1:0] m_wa  = '0;
  logic [DW-1:0] m_wd  = '0;
  logic [DW-1:0] tb_rf [32];

  logic [N-1:0] sb_cand, sb_er;
  logic [31:0]  sb_em;
  int           sb_g;
  wr_t          mon_e;

  regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (valid),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .reg_write_enable (reg_write_enable),
    .write_address    (write_address),
    .write_data       (write_data),
    .pending_mask     (pending_mask)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*DW +: DW] = rd[i];
    end
  end

  // Register file model committing whatever the DUT drives
  always @(posedge clk) begin
    if (reset_n && reg_write_enable) tb_rf[write_address] <= write_data;
  end

  always @(negedge reset_n) begin
    m_ptr = 0;
    m_we  = 1'b0;
    m_wa  = '0;
    m_wd  = '0;
    q.delete();
  end

  // Arbitration model: predicts req_ready / pending_mask and pushes expected writes
  always begin
    @(negedge clk);
    #2;
    sb_er = '0;
    sb_g  = -1;
    for (int i = 0; i < N; i++) sb_cand[i] = valid[i] && (ra[i] != '0);
    if (reset_n) begin
      for (int i = 0; i < N; i++) if (valid[i] && ra[i] == '0) sb_er[i] = 1'b1;
`ifdef WB_ARB_RR_EN
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (sb_g < 0 && sb_cand[idx]) sb_g = idx;
      end
`else
      for (int i = N - 1; i >= 0; i--) if (sb_cand[i]) sb_g = i;
`endif
      if (sb_g >= 0) begin
        sb_er[sb_g] = 1'b1;
        q.push_back('{a: ra[sb_g], d: rd[sb_g]});
        m_ptr = (sb_g + 1) % N;
      end
    end
    sb_em = '0;
    for (int r = 1; r < 32; r++) begin
      if (m_we && m_wa == AW'(r)) sb_em[r] = 1'b1;
      for (int i = 0; i < N; i++) if (sb_cand[i] && ra[i] == AW'(r)) sb_em[r] = 1'b1;
    end
    n_vec++;
    if (req_ready !== sb_er) begin
      n_err++;
      $display("FAIL sb_ready t=%0t got %b exp %b", $time, req_ready, sb_er);
    end
    n_vec++;
    if (pending_mask !== sb_em) begin
      n_err++;
      $display("FAIL sb_pending_mask t=%0t got %h exp %h", $time, pending_mask, sb_em);
    end
  end

  // Output monitor: pops the expected write one edge after acceptance
  always begin
    @(posedge clk);
    #1;
    if (reset_n) begin
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        m_we  = 1'b1;
        m_wa  = mon_e.a;
        m_wd  = mon_e.d;
      end else begin
        m_we = 1'b0;
      end
      n_vec++;
      if ({reg_write_enable, write_address, write_data} !== {m_we, m_wa, m_wd}) begin
        n_err++;
        $display("FAIL sb_output t=%0t got en=%b a=%0d d=%h exp en=%b a=%0d d=%h", $time,
                 reg_write_enable, write_address, write_data, m_we, m_wa, m_wd);
      end
    end
  end

  task automatic clear_inputs();
    valid = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rd[i] = '0;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    valid[0] = 1'b1; ra[0] = 5'd3; rd[0] = 32'h0000_0033;
    #3;
    n_vec++;
    if (req_ready !== 3'b000) begin
      n_err++; $display("FAIL reset_ready got %b exp 000", req_ready);
    end
    n_vec++;
    if ({reg_write_enable, write_address, write_data} !== '0) begin
      n_err++; $display("FAIL reset_outputs got en=%b a=%0d d=%h exp zeros", reg_write_enable, write_address, write_data);
    end
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    valid[0] = 1'b1; ra[0] = 5'd5; rd[0] = 32'h5555_0005;
    @(negedge clk);
    valid[0] = 1'b0;
    n_vec++;
    if (reg_write_enable !== 1'b1) begin
      n_err++; $display("FAIL midwrite_inflight got en=%b exp 1", reg_write_enable);
    end
    valid[1] = 1'b1; ra[1] = 5'd9; rd[1] = 32'h0000_0009;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({reg_write_enable, write_address, write_data} !== '0) begin
      n_err++; $display("FAIL midwrite_clear got en=%b a=%0d d=%h exp zeros", reg_write_enable, write_address, write_data);
    end
    n_vec++;
    if (req_ready !== 3'b000) begin
      n_err++; $display("FAIL midwrite_ready got %b exp 000", req_ready);
    end
    @(negedge clk);
    clear_inputs();
    n_vec++;
    if (tb_rf[5] !== 32'h0) begin
      n_err++; $display("FAIL midwrite_x5 got %h exp 00000000", tb_rf[5]);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    valid[0] = 1'b1; ra[0] = 5'd5; rd[0] = 32'hDEAD_BEEF;
    #3;
    n_vec++;
    if (req_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL single_ready got %b exp 1", req_ready[0]);
    end
    @(negedge clk);
    valid[0] = 1'b0;
    n_vec++;
    if ({reg_write_enable, write_address, write_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL single_write got en=%b a=%0d d=%h exp en=1 a=5 d=deadbeef", reg_write_enable, write_address, write_data);
    end
    @(negedge clk);
    n_vec++;
    if (reg_write_enable !== 1'b0) begin
      n_err++; $display("FAIL single_enable_drop got %b exp 0", reg_write_enable);
    end
  endtask

  task automatic test_contention();
    logic [N-1:0]  exp_seq [6];
    logic [AW-1:0] last_addr;
`ifdef WB_ARB_RR_EN
    exp_seq   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    last_addr = 5'd3;
`else
    exp_seq   = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    last_addr = 5'd1;
`endif
    reset_pulse();
    for (int i = 0; i < N; i++) begin
      valid[i] = 1'b1;
      ra[i]    = AW'(i + 1);
      rd[i]    = 32'hC000_0000 | 32'(i);
    end
    for (int k = 0; k < 6; k++) begin
      #3;
      n_vec++;
      if (req_ready !== exp_seq[k]) begin
        n_err++; $display("FAIL contention_grant[%0d] got %b exp %b", k, req_ready, exp_seq[k]);
      end
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (exp_seq[k][i]) rd[i] = 32'hC000_0000 | 32'((k + 1) * 256 + i);
    end
    clear_inputs();
    n_vec++;
    if (write_address !== last_addr) begin
      n_err++; $display("FAIL contention_last_addr got %0d exp %0d", write_address, last_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_x0();
    valid[1] = 1'b1; ra[1] = 5'd0; rd[1] = 32'hBAD0_0000;
    valid[0] = 1'b1; ra[0] = 5'd7; rd[0] = 32'h0000_0077;
    #3;
    n_vec++;
    if (req_ready !== 3'b011) begin
      n_err++; $display("FAIL x0_ready got %b exp 011", req_ready);
    end
    n_vec++;
    if (pending_mask[0] !== 1'b0 || pending_mask[7] !== 1'b1) begin
      n_err++; $display("FAIL x0_mask got %h exp bit7 set, bit0 clear", pending_mask);
    end
    @(negedge clk);
    clear_inputs();
    n_vec++;
    if ({reg_write_enable, write_address, write_data} !== {1'b1, 5'd7, 32'h0000_0077}) begin
      n_err++; $display("FAIL x0_write got en=%b a=%0d d=%h exp en=1 a=7 d=00000077", reg_write_enable, write_address, write_data);
    end
    @(negedge clk);
    n_vec++;
    if (reg_write_enable !== 1'b0 || tb_rf[0] !== 32'h0) begin
      n_err++; $display("FAIL x0_single_pulse got en=%b x0=%h exp en=0 x0=00000000", reg_write_enable, tb_rf[0]);
    end
  endtask

  task automatic test_pending();
    reset_pulse();
    valid[0] = 1'b1; ra[0] = 5'd4;  rd[0] = 32'h0000_0004;
    valid[2] = 1'b1; ra[2] = 5'd31; rd[2] = 32'h0000_001F;
    #3;
    n_vec++;
    if (req_ready !== 3'b001 || pending_mask[4] !== 1'b1 || pending_mask[31] !== 1'b1) begin
      n_err++; $display("FAIL pending_first got rdy=%b mask=%h exp rdy=001 bits4,31", req_ready, pending_mask);
    end
    @(negedge clk);
    valid[0] = 1'b0;
    #3;
    n_vec++;
    if (req_ready !== 3'b100 || pending_mask !== 32'h8000_0010) begin
      n_err++; $display("FAIL pending_second got rdy=%b mask=%h exp rdy=100 mask=80000010", req_ready, pending_mask);
    end
    @(negedge clk);
    valid[2] = 1'b0;
    n_vec++;
    if (reg_write_enable !== 1'b1 || pending_mask !== 32'h8000_0000) begin
      n_err++; $display("FAIL pending_output got en=%b mask=%h exp en=1 mask=80000000", reg_write_enable, pending_mask);
    end
    @(negedge clk);
    n_vec++;
    if (pending_mask !== 32'h0) begin
      n_err++; $display("FAIL pending_clear got %h exp 00000000", pending_mask);
    end
  endtask

  task automatic test_back_to_back();
    valid[0] = 1'b1; ra[0] = 5'd10; rd[0] = 32'd1;
    @(negedge clk);
    rd[0] = 32'd2;
    n_vec++;
    if (reg_write_enable !== 1'b1 || write_data !== 32'd1) begin
      n_err++; $display("FAIL b2b_first got en=%b d=%h exp en=1 d=1", reg_write_enable, write_data);
    end
    @(negedge clk);
    clear_inputs();
    n_vec++;
    if (reg_write_enable !== 1'b1 || write_data !== 32'd2) begin
      n_err++; $display("FAIL b2b_second got en=%b d=%h exp en=1 d=2", reg_write_enable, write_data);
    end
    @(negedge clk);
    n_vec++;
    if (reg_write_enable !== 1'b0 || tb_rf[10] !== 32'd2) begin
      n_err++; $display("FAIL b2b_final got en=%b x10=%h exp en=0 x10=2", reg_write_enable, tb_rf[10]);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) tb_rf[r] = '0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_pending();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
